// File: rtl/regfile_scoreboard_pkg.sv
// Shared sizing, types and helpers for the register file / pending scoreboard.
// Optional write-through bypass is enabled by defining REGFILE_BYPASS_EN.
package regfile_scoreboard_pkg;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned NREG      = 32;
  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned CNT_W     = 6;

  localparam logic [REG_IDX_W-1:0] ZERO_REG = '0;

  // One-hot select vector, same shape as the 5-to-32 decoder output.
  typedef logic [NREG-1:0]      onehot_t;
  typedef logic [DATA_W-1:0]    word_t;
  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [CNT_W-1:0]     count_t;

  // Number of set bits among registers 1..NREG-1.
  function automatic count_t popcount(input onehot_t v);
    count_t c;
    c = '0;
    for (int unsigned i = 1; i < NREG; i++) begin
      c = c + count_t'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Writeback, issue and read-port bundle for the register file.
// The slave modport is the register file; the master is the core pipeline.
interface regfile_scoreboard_if;
  import regfile_scoreboard_pkg::*;

  logic     write_enable;
  onehot_t  write_onehot;
  word_t    data_write;
  logic     issue_valid;
  onehot_t  issue_onehot;
  reg_idx_t read_sel_a;
  reg_idx_t read_sel_b;
  word_t    data_read_a;
  word_t    data_read_b;
  logic     pending_a;
  logic     pending_b;
  logic     stall;
  count_t   pending_count;

  modport master (
    output write_enable, write_onehot, data_write,
    output issue_valid, issue_onehot,
    output read_sel_a, read_sel_b,
    input  data_read_a, data_read_b,
    input  pending_a, pending_b, stall, pending_count
  );

  modport slave (
    input  write_enable, write_onehot, data_write,
    input  issue_valid, issue_onehot,
    input  read_sel_a, read_sel_b,
    output data_read_a, data_read_b,
    output pending_a, pending_b, stall, pending_count
  );

endinterface

// File: rtl/regfile_scoreboard_reg_cell.sv
// Single architectural register: load-enable storage with async active-high clear.
module reg_cell #(
  parameter int unsigned W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// 32x32 register file with one-hot writeback, two combinational read ports and
// a per-register pending scoreboard. Define REGFILE_BYPASS_EN for write-through bypass.
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
(
  input logic                 clock,
  input logic                 reset,
  regfile_scoreboard_if.slave bus
);

  word_t   regs [NREG];
  onehot_t pending;
  onehot_t pending_next;
  count_t  count;

  logic    pend_a;
  logic    pend_b;
  word_t   rd_a;
  word_t   rd_b;

  assign regs[0] = '0;

  for (genvar i = 1; i < NREG; i++) begin : g_cell
    reg_cell #(.W(DATA_W)) u_cell (
      .clock (clock),
      .reset (reset),
      .en    (bus.write_enable & bus.write_onehot[i]),
      .d     (bus.data_write),
      .q     (regs[i])
    );
  end

  // Issue outranks a same-cycle writeback: the newer producer stays outstanding.
  always_comb begin
    pending_next = pending;
    for (int unsigned i = 0; i < NREG; i++) begin
      if (bus.issue_valid && bus.issue_onehot[i]) begin
        pending_next[i] = 1'b1;
      end else if (bus.write_enable && bus.write_onehot[i]) begin
        pending_next[i] = 1'b0;
      end
    end
    pending_next[ZERO_REG] = 1'b0;
  end

  // Count is registered alongside the bits it summarises, so it never lags them.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending <= '0;
      count   <= '0;
    end else begin
      pending <= pending_next;
      count   <= popcount(pending_next);
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic hit_a;
  logic hit_b;

  always_comb begin
    hit_a = bus.write_enable & bus.write_onehot[bus.read_sel_a] & (bus.read_sel_a != ZERO_REG);
    hit_b = bus.write_enable & bus.write_onehot[bus.read_sel_b] & (bus.read_sel_b != ZERO_REG);
    rd_a   = hit_a ? bus.data_write : regs[bus.read_sel_a];
    rd_b   = hit_b ? bus.data_write : regs[bus.read_sel_b];
    pend_a = hit_a ? (bus.issue_valid & bus.issue_onehot[bus.read_sel_a]) : pending[bus.read_sel_a];
    pend_b = hit_b ? (bus.issue_valid & bus.issue_onehot[bus.read_sel_b]) : pending[bus.read_sel_b];
  end
`else
  always_comb begin
    rd_a   = regs[bus.read_sel_a];
    rd_b   = regs[bus.read_sel_b];
    pend_a = pending[bus.read_sel_a];
    pend_b = pending[bus.read_sel_b];
  end
`endif

  assign bus.data_read_a   = rd_a;
  assign bus.data_read_b   = rd_b;
  assign bus.pending_a     = pend_a;
  assign bus.pending_b     = pend_b;
  assign bus.stall         = pend_a | pend_b;
  assign bus.pending_count = count;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed and randomized checks of regfile_scoreboard against an array-based model.
module tb_regfile_scoreboard;
  import regfile_scoreboard_pkg::*;

  logic clock;
  logic reset;

  regfile_scoreboard_if bus();

  regfile_scoreboard dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] mregs [32];
  bit          mpend [32];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      mregs[i] = '0;
      mpend[i] = 1'b0;
    end
  endtask

  function automatic logic [31:0] exp_data(input logic [4:0] sel);
    if (sel == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
    if (bus.write_enable && bus.write_onehot[sel]) return bus.data_write;
`endif
    return mregs[sel];
  endfunction

  function automatic logic exp_pend(input logic [4:0] sel);
    if (sel == 5'd0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (bus.write_enable && bus.write_onehot[sel]) return bus.issue_valid && bus.issue_onehot[sel];
`endif
    return mpend[sel];
  endfunction

  function automatic logic [31:0] exp_count();
    int c;
    c = 0;
    for (int i = 0; i < 32; i++) c += int'(mpend[i]);
    return 32'(c);
  endfunction

  task automatic check_all(input string tag);
    logic pa;
    logic pb;
    pa = exp_pend(bus.read_sel_a);
    pb = exp_pend(bus.read_sel_b);
    chk({tag, ".rda"},   bus.data_read_a, exp_data(bus.read_sel_a));
    chk({tag, ".rdb"},   bus.data_read_b, exp_data(bus.read_sel_b));
    chk({tag, ".pa"},    32'(bus.pending_a), 32'(pa));
    chk({tag, ".pb"},    32'(bus.pending_b), 32'(pb));
    chk({tag, ".stall"}, 32'(bus.stall), 32'(pa | pb));
    chk({tag, ".cnt"},   32'(bus.pending_count), exp_count());
  endtask

  task automatic drive(input logic we, input logic [31:0] wo, input logic [31:0] dw,
                       input logic iv, input logic [31:0] io,
                       input logic [4:0] sa, input logic [4:0] sb);
    bus.write_enable = we;
    bus.write_onehot = wo;
    bus.data_write   = dw;
    bus.issue_valid  = iv;
    bus.issue_onehot = io;
    bus.read_sel_a   = sa;
    bus.read_sel_b   = sb;
  endtask

  // Advance one rising edge, applying the architectural rules to the model.
  task automatic step();
    @(posedge clock);
    for (int i = 1; i < 32; i++) begin
      if (bus.write_enable && bus.write_onehot[i]) mregs[i] = bus.data_write;
      if (bus.issue_valid && bus.issue_onehot[i]) mpend[i] = 1'b1;
      else if (bus.write_enable && bus.write_onehot[i]) mpend[i] = 1'b0;
    end
    #1;
  endtask

  function automatic logic [31:0] rand_onehot();
    int unsigned mode;
    mode = $urandom_range(0, 9);
    if (mode == 0) return 32'd0;
    if (mode == 1) return $urandom;
    return 32'(1) << $urandom_range(0, 31);
  endfunction

  initial begin
    reset = 1'b1;
    drive(1'b0, '0, '0, 1'b0, '0, 5'd5, 5'd31);
    model_reset();
    #12;
    check_all("reset");
    reset = 1'b0;

    // Write reg 3: old value visible before the edge, new value after.
    drive(1'b1, 32'h0000_0008, 32'hDEADBEEF, 1'b0, '0, 5'd3, 5'd31);
    #1;
    check_all("wr3_same");
    step();
    drive(1'b0, '0, '0, 1'b0, '0, 5'd3, 5'd3);
    #1;
    check_all("wr3_next");
    chk("wr3_val", bus.data_read_a, 32'hDEADBEEF);

    // Register 0 ignores writes.
    drive(1'b1, 32'h0000_0001, 32'h12345678, 1'b0, '0, 5'd0, 5'd0);
    #1;
    check_all("wr0_same");
    step();
    drive(1'b0, '0, '0, 1'b0, '0, 5'd0, 5'd0);
    #1;
    check_all("wr0_next");
    chk("r0_zero", bus.data_read_a, 32'd0);
    chk("r0_cnt", 32'(bus.pending_count), 32'd0);

    // Issue reg 10 then retire it.
    drive(1'b0, '0, '0, 1'b1, 32'h0000_0400, 5'd0, 5'd10);
    #1;
    check_all("iss10_same");
    step();
    drive(1'b0, '0, '0, 1'b0, '0, 5'd0, 5'd10);
    #1;
    check_all("iss10_next");
    chk("iss10_pb", 32'(bus.pending_b), 32'd1);
    chk("iss10_stall", 32'(bus.stall), 32'd1);
    chk("iss10_cnt", 32'(bus.pending_count), 32'd1);
    drive(1'b1, 32'h0000_0400, 32'h0000_A5A5, 1'b0, '0, 5'd0, 5'd10);
    #1;
    check_all("ret10_same");
    step();
    drive(1'b0, '0, '0, 1'b0, '0, 5'd0, 5'd10);
    #1;
    check_all("ret10_next");
    chk("ret10_pb", 32'(bus.pending_b), 32'd0);
    chk("ret10_cnt", 32'(bus.pending_count), 32'd0);
    chk("ret10_data", bus.data_read_b, 32'h0000_A5A5);

    // Issue reg 7, then issue and write reg 7 together: stays pending.
    drive(1'b0, '0, '0, 1'b1, 32'h0000_0080, 5'd7, 5'd0);
    step();
    drive(1'b1, 32'h0000_0080, 32'h0000_0077, 1'b1, 32'h0000_0080, 5'd7, 5'd0);
    #1;
    check_all("iw7_same");
`ifdef REGFILE_BYPASS_EN
    chk("iw7_bypass", bus.data_read_a, 32'h0000_0077);
`endif
    step();
    drive(1'b0, '0, '0, 1'b0, '0, 5'd7, 5'd0);
    #1;
    check_all("iw7_next");
    chk("iw7_pa", 32'(bus.pending_a), 32'd1);
    chk("iw7_cnt", 32'(bus.pending_count), 32'd1);
    chk("iw7_data", bus.data_read_a, 32'h0000_0077);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 1)), rand_onehot(), $urandom,
            1'($urandom_range(0, 2) == 0), rand_onehot(),
            5'($urandom), 5'($urandom));
      #1;
      check_all("rand");
      step();
    end

    // Clear everything, then issue regs 1..31 on successive cycles.
    drive(1'b1, '1, '0, 1'b0, '0, 5'd0, 5'd0);
    step();
    drive(1'b0, '0, '0, 1'b0, '0, 5'd0, 5'd0);
    #1;
    check_all("clear");
    chk("clear_cnt", 32'(bus.pending_count), 32'd0);
    for (int r = 1; r < 32; r++) begin
      drive(1'b0, '0, '0, 1'b1, 32'(1) << r, 5'(r), 5'(r - 1));
      step();
      check_all("fill");
      chk("fill_cnt", 32'(bus.pending_count), 32'(r));
    end

    // Asynchronous reset between edges, with an issue still being driven.
    drive(1'b1, 32'h0000_0008, 32'hFFFF_0000, 1'b1, 32'h0000_0100, 5'd3, 5'd8);
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    bus.write_enable = 1'b0;
    bus.issue_valid  = 1'b0;
    #1;
    check_all("arst");
    chk("arst_cnt", 32'(bus.pending_count), 32'd0);
    chk("arst_stall", 32'(bus.stall), 32'd0);
    reset = 1'b0;
    step();
    check_all("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- 32 x 32-bit architectural register file for the miner's soft core. Sits directly downstream of the 5-to-32 write-select decoder.
- Consumes the one-hot write-select vector and writes data at the clock edge.
- Provides two combinational read ports.
- Tracks in-flight destination registers in a per-register pending scoreboard and raises a stall when a source register is still pending.

Parameters:
- DATA_W, 32, register width in bits
- NREG, 32, number of registers; fixed to decoder output width; register 0 hardwired to zero

Ports:
- clock  input  1  system clock, rising-edge active
- reset  input  1  asynchronous, active-high; clears all state
- write_enable  input  1  qualifies a writeback this cycle
- write_onehot  input  NREG  one-hot write select from decoder
- data_write  input  DATA_W  writeback data
- issue_valid  input  1  an instruction with a destination register is issuing
- issue_onehot  input  NREG  one-hot destination select for the issuing instruction (second decoder instance)
- read_sel_a  input  5  source A index
- read_sel_b  input  5  source B index
- data_read_a  output  DATA_W  register[read_sel_a]
- data_read_b  output  DATA_W  register[read_sel_b]
- pending_a  output  1  source A has an outstanding write
- pending_b  output  1  source B has an outstanding write
- stall  output  1  pending_a | pending_b
- pending_count  output  6  number of set pending bits (0..31)

Behaviour:
- Reset (async, active-high): all registers 0, all pending bits 0, pending_count 0. Outputs follow combinationally: reads 0, pending/stall 0. A reset asserted mid-operation discards in-flight writes and issues on that edge.
- Write: on rising clock, for each i in 1..31 with write_enable & write_onehot[i], reg[i] <= data_write.
  - Multiple bits set: every selected register is written. This is defined behaviour; the decoder never produces it.
  - write_onehot all zero: no write.
- Register 0: reads always 0. Writes are ignored. pending[0] is never set.
- Reads: purely combinational mux, zero latency; a write becomes visible the cycle after its clock edge (without the optional feature).
- Scoreboard, per register i (1..31), next-state priority:
  - issue_valid & issue_onehot[i] -> pending[i] <= 1. Issue wins over a same-cycle write to the same register; the new producer is outstanding.
  - else write_enable & write_onehot[i] -> pending[i] <= 0.
  - else hold.
- A write to a non-pending register is legal: it updates the data and leaves pending at 0.
- pending_a = pending[read_sel_a]; pending_b = pending[read_sel_b]; both 0 when the selector is 0.
- pending_count is registered and updated in the same edge as the pending bits. It equals the popcount of pending[31:1], so the maximum is 31; wrap is impossible.
- Latency: write data 1 cycle; issue-to-pending 1 cycle; write-to-clear 1 cycle.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined: write-through bypass. If write_enable & write_onehot[read_sel_x] & read_sel_x != 0, then data_read_x = data_write in the same cycle, and pending_x = 0 unless issue_valid & issue_onehot[read_sel_x] in that cycle. stall uses the bypassed pending values.
- Undefined: no bypass. Reads return stored values; pending bits clear one cycle after the write.

Decomposition:
- Shared package holds:
  - DATA_W, NREG, REG_IDX_W = 5
  - ZERO_REG = 0
  - the one-hot vector typedef shared with the decoder
- One natural sub-module, reg_cell: a DATA_W-bit register with enable and async active-high clear. Instantiated 31 times; index 0 is a constant.
- The scoreboard bits and read muxes stay inline.

Test Plan:
- Reset then read sel 5/31 -> data_read_a = 0, data_read_b = 0, stall = 0, pending_count = 0.
- write_enable = 1, write_onehot = 0x0000_0008, data = 0xDEADBEEF; next cycle read_sel_a = 3 -> 0xDEADBEEF. Same cycle read (no bypass) -> old value 0.
- Write 0x12345678 with write_onehot = 0x0000_0001 -> read_sel_a = 0 returns 0, pending_count stays 0.
- issue_valid with issue_onehot = 0x0000_0400 -> next cycle read_sel_b = 10 gives pending_b = 1, stall = 1, count = 1. Write reg 10 -> next cycle pending_b = 0, count = 0.
- Same cycle: issue reg 7 and write reg 7 with pending[7] = 1 -> pending[7] stays 1, count unchanged. With REGFILE_BYPASS_EN, data_read_a = data_write in that cycle.
- Issue regs 1..31 on successive cycles -> count reaches 31. Assert reset asynchronously mid-clock -> count = 0, all pending 0 immediately.
